// File: rtl/spi_adc_scanner.sv
// Round-robin scanner for an MCP300x-style SPI ADC: walks the enabled channels,
// runs one conversion frame per channel and keeps the latest result of each.
module spi_adc_scanner #(
   parameter int NUM_CH   = 4,
   parameter int RES_BITS = 10,
   parameter int CLK_DIV  = 50,
   parameter int GAP_CYC  = 1000,
   parameter int SGL      = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         enable,
   input  logic [NUM_CH-1:0]            ch_mask,
   input  logic                         dout,
   output logic                         cs,
   output logic                         sclk,
   output logic                         din,
   output logic [NUM_CH*RES_BITS-1:0]   sample,
   output logic                         sample_valid,
   output logic [2:0]                   sample_ch,
   output logic                         busy
);

   localparam int FRAME   = 7 + RES_BITS;
   localparam int CNT_MAX = (GAP_CYC > CLK_DIV) ? GAP_CYC : CLK_DIV;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] DIV_END     = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_END     = CNT_W'(GAP_CYC - 1);
   localparam logic [4:0]       LAST_BIT    = 5'(FRAME - 1);
   localparam logic [4:0]       CAP_FIRST   = 5'd6;
   localparam logic [4:0]       CAP_LAST    = 5'(5 + RES_BITS);
   localparam logic [2:0]       LAST_CH_RST = 3'(NUM_CH - 1);

   typedef enum logic [1:0] {IDLE, SETUP, XFER, GAP} state_e;

   state_e                      state_q;
   logic [CNT_W-1:0]            cnt_q;
   logic [4:0]                  bit_q;
   logic                        high_q;
   logic [2:0]                  ch_q;
   logic [2:0]                  last_q;
   logic [RES_BITS-1:0]         shift_q;
   logic [NUM_CH*RES_BITS-1:0]  sample_q;
   logic                        valid_q;
   logic [2:0]                  sample_ch_q;
   logic                        cs_q;
   logic                        sclk_q;
   logic                        din_q;

   logic       start_ok;
   logic       in_frame;
   logic [2:0] sel_ch;

   // Lowest enabled channel above the last converted one, else wrap to the lowest enabled.
   function automatic logic [2:0] next_channel(input logic [NUM_CH-1:0] mask,
                                               input logic [2:0]        last);
      logic [2:0] first;
      logic [2:0] above;
      logic       have_first;
      logic       have_above;
      first      = '0;
      above      = '0;
      have_first = 1'b0;
      have_above = 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
         if (mask[n]) begin
            if (!have_first) begin
               first      = 3'(n);
               have_first = 1'b1;
            end
            if (!have_above && (3'(n) > last)) begin
               above      = 3'(n);
               have_above = 1'b1;
            end
         end
      end
      return have_above ? above : first;
   endfunction

   function automatic logic cmd_bit(input logic [4:0] idx, input logic [2:0] ch);
      case (idx)
         5'd0:    return 1'b1;
         5'd1:    return (SGL != 0);
         5'd2:    return ch[2];
         5'd3:    return ch[1];
         5'd4:    return ch[0];
         default: return 1'b0;
      endcase
   endfunction

   assign start_ok = enable && (ch_mask != '0);
   assign in_frame = (state_q == SETUP) || (state_q == XFER);
   assign sel_ch   = next_channel(ch_mask, last_q);

   // NOTE: every register here, including the sample bank, is state and uses non-blocking
   // assignments; the sample bank is a handful of flops, so it is reset like the rest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         high_q      <= 1'b0;
         ch_q        <= '0;
         last_q      <= LAST_CH_RST;
         shift_q     <= '0;
         sample_q    <= '0;
         valid_q     <= 1'b0;
         sample_ch_q <= '0;
         cs_q        <= 1'b1;
         sclk_q      <= 1'b0;
         din_q       <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (in_frame && !enable) begin
            // Abort drops the frame but still serves the full chip-select high time.
            state_q <= GAP;
            cnt_q   <= '0;
            high_q  <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            din_q   <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  cs_q   <= 1'b1;
                  sclk_q <= 1'b0;
                  din_q  <= 1'b0;
                  if (start_ok) begin
                     ch_q    <= sel_ch;
                     state_q <= SETUP;
                     cnt_q   <= '0;
                     cs_q    <= 1'b0;
                     din_q   <= 1'b1;
                  end
               end
               SETUP: begin
                  if (cnt_q == DIV_END) begin
                     state_q <= XFER;
                     cnt_q   <= '0;
                     bit_q   <= '0;
                     high_q  <= 1'b1;
                     sclk_q  <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               XFER: begin
                  if (cnt_q != DIV_END) begin
                     cnt_q <= cnt_q + 1'b1;
                  end else begin
                     cnt_q <= '0;
                     if (high_q) begin
                        high_q <= 1'b0;
                        sclk_q <= 1'b0;
                        din_q  <= cmd_bit(bit_q + 5'd1, ch_q);
                     end else if (bit_q == LAST_BIT) begin
                        for (int n = 0; n < NUM_CH; n++) begin
                           if (ch_q == 3'(n)) sample_q[n*RES_BITS +: RES_BITS] <= shift_q;
                        end
                        valid_q     <= 1'b1;
                        sample_ch_q <= ch_q;
                        last_q      <= ch_q;
                        state_q     <= GAP;
                        cs_q        <= 1'b1;
                        din_q       <= 1'b0;
                     end else begin
                        high_q <= 1'b1;
                        sclk_q <= 1'b1;
                        bit_q  <= bit_q + 5'd1;
                        // Rising edge of the next period: result bits live in periods 7..6+RES_BITS.
                        if ((bit_q >= CAP_FIRST) && (bit_q <= CAP_LAST))
                           shift_q <= {shift_q[RES_BITS-2:0], dout};
                     end
                  end
               end
               GAP: begin
                  if (cnt_q == GAP_END) begin
                     cnt_q <= '0;
                     if (start_ok) begin
                        ch_q    <= sel_ch;
                        state_q <= SETUP;
                        cs_q    <= 1'b0;
                        din_q   <= 1'b1;
                     end else begin
                        state_q <= IDLE;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign cs           = cs_q;
   assign sclk         = sclk_q;
   assign din          = din_q;
   assign sample       = sample_q;
   assign sample_valid = valid_q;
   assign sample_ch    = sample_ch_q;
   assign busy         = ~cs_q;

endmodule

// File: tb/tb_spi_adc_scanner.sv
// Directed bench for spi_adc_scanner with a behavioural MCP300x-style ADC model
// that decodes the command and shifts back a per-channel result.
module tb_spi_adc_scanner;

   localparam int NUM_CH   = 4;
   localparam int RES_BITS = 10;
   localparam int CLK_DIV  = 2;
   localparam int GAP_CYC  = 8;
   localparam int SGL      = 1;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        enable   = 1'b0;
   logic [3:0]  ch_mask  = 4'b0000;
   logic        dout     = 1'b0;
   logic        cs;
   logic        sclk;
   logic        din;
   logic [39:0] sample;
   logic        sample_valid;
   logic [2:0]  sample_ch;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [9:0] adc_val  [4];
   logic [9:0] exp_slot [4];

   int         m_per         = 0;
   logic [4:0] m_cmd         = '0;
   logic [2:0] m_ch          = '0;
   logic [9:0] m_res         = '0;
   int         frame_periods = 0;
   logic       sclk_prev     = 1'b0;
   logic       cs_prev       = 1'b1;
   int         valid_cnt     = 0;

   spi_adc_scanner #(
      .NUM_CH   (NUM_CH),
      .RES_BITS (RES_BITS),
      .CLK_DIV  (CLK_DIV),
      .GAP_CYC  (GAP_CYC),
      .SGL      (SGL)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .ch_mask      (ch_mask),
      .dout         (dout),
      .cs           (cs),
      .sclk         (sclk),
      .din          (din),
      .sample       (sample),
      .sample_valid (sample_valid),
      .sample_ch    (sample_ch),
      .busy         (busy)
   );

   initial forever #5 clk = ~clk;

   // ADC model: command in on rising edges of periods 0..4, result out on falling
   // edges of periods 6..15 so the scanner sees MSB first at period 7.
   always @(sclk or cs) begin
      if (cs === 1'b0 && cs_prev === 1'b1) begin
         m_per = 0;
         m_cmd = '0;
         dout  = 1'b0;
      end else if (cs === 1'b1 && cs_prev !== 1'b1) begin
         frame_periods = m_per;
         m_per         = 0;
         dout          = 1'b0;
      end
      if (cs === 1'b0) begin
         if (sclk === 1'b1 && sclk_prev === 1'b0) begin
            if (m_per < 5) m_cmd = {m_cmd[3:0], din};
            if (m_per == 4) begin
               m_ch  = m_cmd[2:0];
               m_res = adc_val[m_ch[1:0]];
            end
         end else if (sclk === 1'b0 && sclk_prev === 1'b1) begin
            if (m_per >= 6 && m_per <= 15) dout = m_res[4'(15 - m_per)];
            m_per++;
         end
      end
      sclk_prev = sclk;
      cs_prev   = cs;
   end

   always @(negedge clk) if (sample_valid === 1'b1) valid_cnt++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [39:0] exp_vec();
      return {exp_slot[3], exp_slot[2], exp_slot[1], exp_slot[0]};
   endfunction

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (sample_valid !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_timeout"}, 64'(n < 300), 64'(1));
   endtask

   task automatic expect_frame(input string tag, input logic [2:0] ch);
      wait_valid(tag);
      exp_slot[ch[1:0]] = adc_val[ch[1:0]];
      check({tag, "_ch"},      64'(sample_ch),     64'(ch));
      check({tag, "_cmd"},     64'(m_cmd),         64'({2'b11, ch}));
      check({tag, "_periods"}, 64'(frame_periods), 64'(17));
      check({tag, "_sample"},  64'(sample),        64'(exp_vec()));
      @(negedge clk);
      check({tag, "_pulse"},   64'(sample_valid),  64'(0));
   endtask

   task automatic clear_expected();
      for (int i = 0; i < 4; i++) exp_slot[i] = '0;
   endtask

   initial begin
      int v0;
      int n;
      int hi_cnt;
      int cs_low_seen;
      int sclk_hi_seen;

      adc_val[0] = 10'd5;
      adc_val[1] = 10'd105;
      adc_val[2] = 10'd205;
      adc_val[3] = 10'd305;
      clear_expected();

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_cs",     64'(cs),           64'(1));
      check("rst_sclk",   64'(sclk),         64'(0));
      check("rst_din",    64'(din),          64'(0));
      check("rst_sample", 64'(sample),       64'(0));
      check("rst_valid",  64'(sample_valid), 64'(0));
      check("rst_ch",     64'(sample_ch),    64'(0));
      check("rst_busy",   64'(busy),         64'(0));

      // Full mask: round robin 0,1,2,3,0
      ch_mask = 4'b1111;
      enable  = 1'b1;
      rst_n   = 1'b1;
      v0      = valid_cnt;
      expect_frame("f0", 3'd0);
      expect_frame("f1", 3'd1);
      expect_frame("f2", 3'd2);
      expect_frame("f3", 3'd3);
      check("f3_slots", 64'(sample), 64'({10'd305, 10'd205, 10'd105, 10'd5}));
      expect_frame("f4", 3'd0);
      check("rr_pulses", 64'(valid_cnt - v0), 64'(5));
      repeat (12) @(negedge clk);
      check("busy_in_frame", 64'({cs, busy}), 64'(2'b01));
      enable = 1'b0;
      repeat (15) @(negedge clk);

      // Sparse mask after reset: 1,3,1 with slots 0 and 2 left at zero
      rst_n = 1'b0;
      @(negedge clk);
      clear_expected();
      check("rst2_sample", 64'(sample), 64'(0));
      ch_mask = 4'b1010;
      rst_n   = 1'b1;
      enable  = 1'b1;
      expect_frame("m1",  3'd1);
      expect_frame("m3",  3'd3);
      expect_frame("m1b", 3'd1);
      check("m_slots", 64'(sample), 64'({10'd305, 10'd0, 10'd105, 10'd0}));
      enable = 1'b0;
      repeat (15) @(negedge clk);

      // Full-scale then zero on channel 0
      ch_mask    = 4'b0001;
      adc_val[0] = 10'h3FF;
      v0         = valid_cnt;
      enable     = 1'b1;
      expect_frame("max", 3'd0);
      check("max_slot0", 64'(sample[9:0]), 64'(1023));
      adc_val[0] = 10'h000;
      expect_frame("min", 3'd0);
      check("min_slot0", 64'(sample[9:0]), 64'(0));
      check("minmax_pulses", 64'(valid_cnt - v0), 64'(2));

      // Drop enable during sclk period 9
      adc_val[0] = 10'h2AA;
      n = 0;
      while (!(cs === 1'b0 && m_per == 9 && sclk === 1'b1) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("abort_reach", 64'(n < 300), 64'(1));
      enable = 1'b0;
      v0     = valid_cnt;
      @(negedge clk);
      check("abort_cs",   64'(cs),   64'(1));
      check("abort_sclk", 64'(sclk), 64'(0));
      check("abort_busy", 64'(busy), 64'(0));
      enable = 1'b1;
      hi_cnt = 1;
      while (hi_cnt < 100) begin
         @(negedge clk);
         if (cs !== 1'b1) break;
         hi_cnt++;
      end
      check("abort_gap",    64'(hi_cnt >= 8 && hi_cnt < 100), 64'(1));
      check("abort_novalid", 64'(valid_cnt - v0), 64'(0));
      check("abort_sample", 64'(sample), 64'(exp_vec()));

      // Asynchronous reset in the middle of the restarted frame
      n = 0;
      while (!(cs === 1'b0 && m_per == 1 && sclk === 1'b1) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("rst3_reach", 64'(n < 300), 64'(1));
      #3;
      rst_n = 1'b0;
      #1;
      clear_expected();
      check("rst3_cs",     64'(cs),           64'(1));
      check("rst3_sclk",   64'(sclk),         64'(0));
      check("rst3_din",    64'(din),          64'(0));
      check("rst3_busy",   64'(busy),         64'(0));
      check("rst3_valid",  64'(sample_valid), 64'(0));
      check("rst3_sample", 64'(sample),       64'(0));
      check("rst3_ch",     64'(sample_ch),    64'(0));
      ch_mask = 4'b1101;
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      expect_frame("post_rst", 3'd0);
      enable = 1'b0;
      repeat (15) @(negedge clk);

      // Empty mask keeps the bus idle; enabling channel 2 starts a frame there
      ch_mask      = 4'b0000;
      enable       = 1'b1;
      cs_low_seen  = 0;
      sclk_hi_seen = 0;
      repeat (100) begin
         @(negedge clk);
         if (cs !== 1'b1) cs_low_seen++;
         if (sclk !== 1'b0) sclk_hi_seen++;
      end
      check("nomask_cs",   64'(cs_low_seen),  64'(0));
      check("nomask_sclk", 64'(sclk_hi_seen), 64'(0));
      ch_mask = 4'b0100;
      expect_frame("ch2", 3'd2);
      check("ch2_slots", 64'(sample), 64'({10'd0, 10'd205, 10'd0, 10'h2AA}));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
